// File: rtl/range_ctrl_pkg.sv
// range_ctrl_pkg: sequencer state encoding and pushbutton bit positions shared by
// range_ctrl and its testbench.
package range_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_LOW,
      WAIT_HIGH,
      BROWSE
   } state_t;

   localparam int KEY_INC = 0;
   localparam int KEY_DEC = 1;
   localparam int KEY_CLR = 2;
   localparam int KEY_GO  = 3;

endpackage

// File: rtl/key_repeat.sv
// key_repeat: one active-low pushbutton -> synchronized level, press edge and a step
// strobe that fires on the press and then on every tick once held for HOLD_TICKS ticks.
module key_repeat #(
   parameter int HOLD_TICKS = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   input  logic tick,
   output logic step
);

   localparam int CNT_BITS = $clog2(HOLD_TICKS + 1);

   logic [1:0]          sync_q;
   logic                prev_q;
   logic                held;
   logic                press;
   logic                repeat_ok;
   logic [CNT_BITS-1:0] hold_cnt;

   // Released level is 1, so a reset never fabricates a press edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], key_n};
         prev_q <= sync_q[1];
      end
   end

   assign held      = ~sync_q[1];
   assign press     = prev_q & ~sync_q[1];
   assign repeat_ok = (hold_cnt == CNT_BITS'(HOLD_TICKS));

   // Hold counter saturates at HOLD_TICKS; from then on every tick is a repeat step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (!held) begin
         hold_cnt <= '0;
      end else if (tick && !repeat_ok) begin
         hold_cnt <= hold_cnt + CNT_BITS'(1);
      end
   end

   assign step = press | (held & tick & repeat_ok);

endmodule

// File: rtl/range_ctrl.sv
// range_ctrl: launches a Collatz `range` run from a pushbutton, waits for done, then
// browses RAM by offset. Optional watchdog enabled with `define RANGE_CTRL_TIMEOUT_EN.
module range_ctrl
   import range_ctrl_pkg::*;
#(
   parameter int TICK_BITS    = 22,
   parameter int HOLD_TICKS   = 4,
   parameter int OFS_BITS     = 8,
   parameter int TIMEOUT_BITS = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_n,
   input  logic [9:0]  sw,
   input  logic        done,
   input  logic [15:0] count_in,
   output logic        go,
   output logic [31:0] start,
   output logic [11:0] n_disp,
   output logic [15:0] count_disp,
   output logic        busy,
   output logic        timeout
);

   state_t                state;
   state_t                state_next;
   logic [TICK_BITS-1:0]  prescaler;
   logic                  tick;
   logic [1:0]            ctl_s1;
   logic [1:0]            ctl_s2;
   logic                  go_prev;
   logic                  go_edge;
   logic                  clr_held;
   logic                  inc_step;
   logic                  dec_step;
   logic                  wd_expired;
   logic [9:0]            base;
   logic [OFS_BITS-1:0]   offset;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prescaler <= '0;
      else        prescaler <= prescaler + TICK_BITS'(1);
   end

   assign tick = (prescaler == '0);

   key_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n[KEY_INC]),
      .tick  (tick),
      .step  (inc_step)
   );

   key_repeat #(.HOLD_TICKS(HOLD_TICKS)) u_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n[KEY_DEC]),
      .tick  (tick),
      .step  (dec_step)
   );

   // Clear and launch need no auto-repeat: bit 0 is clear, bit 1 is launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_s1  <= 2'b11;
         ctl_s2  <= 2'b11;
         go_prev <= 1'b1;
      end else begin
         ctl_s1  <= {key_n[KEY_GO], key_n[KEY_CLR]};
         ctl_s2  <= ctl_s1;
         go_prev <= ctl_s2[1];
      end
   end

   assign clr_held = ~ctl_s2[0];
   assign go_edge  = go_prev & ~ctl_s2[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // WAIT_LOW swallows a done still high from the previous run before looking for the new one.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, BROWSE: if (go_edge) state_next = LAUNCH;
         LAUNCH:       state_next = WAIT_LOW;
         WAIT_LOW:     if (!done) state_next = WAIT_HIGH;
         WAIT_HIGH:    if (done) state_next = BROWSE;
         default:      state_next = IDLE;
      endcase
      if (wd_expired) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go         <= 1'b0;
         base       <= '0;
         offset     <= '0;
         count_disp <= '0;
      end else begin
         go <= (state_next == LAUNCH);
         if (state_next == LAUNCH) base <= sw;
         if (clr_held)                               offset <= '0;
         else if (state == BROWSE && inc_step)       offset <= offset + OFS_BITS'(1);
         else if (state == BROWSE && dec_step)       offset <= offset - OFS_BITS'(1);
         if (state == BROWSE) count_disp <= count_in;
      end
   end

`ifdef RANGE_CTRL_TIMEOUT_EN
   logic [TIMEOUT_BITS-1:0] wd_cnt;
   logic                    waiting;

   assign waiting    = (state == WAIT_LOW) || (state == WAIT_HIGH);
   assign wd_expired = waiting && (&wd_cnt);

   // Expiry wins over a simultaneous launch press so the flag is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (state == LAUNCH) wd_cnt <= '0;
         else if (waiting)    wd_cnt <= wd_cnt + TIMEOUT_BITS'(1);
         if (wd_expired)      timeout <= 1'b1;
         else if (go_edge)    timeout <= 1'b0;
      end
   end
`else
   assign wd_expired = 1'b0;
   assign timeout    = 1'b0;
`endif

   assign busy   = (state == LAUNCH) || (state == WAIT_LOW) || (state == WAIT_HIGH);
   assign start  = (state == BROWSE) ? 32'(offset) : 32'(base);
   assign n_disp = 12'(base) + 12'(offset);

endmodule

// File: tb/tb_range_ctrl.sv
// tb_range_ctrl: scoreboard bench for range_ctrl with a short prescaler (TICK_BITS=4,
// HOLD_TICKS=2); the watchdog scenario runs when RANGE_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_range_ctrl;
   import range_ctrl_pkg::*;

   localparam int TICK_BITS    = 4;
   localparam int HOLD_TICKS   = 2;
   localparam int OFS_BITS     = 8;
   localparam int TIMEOUT_BITS = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  key_n = 4'hF;
   logic [9:0]  sw = '0;
   logic        done = 1'b0;
   logic [15:0] count_in = '0;
   logic        go;
   logic [31:0] start;
   logic [11:0] n_disp;
   logic [15:0] count_disp;
   logic        busy;
   logic        timeout;

   range_ctrl #(
      .TICK_BITS    (TICK_BITS),
      .HOLD_TICKS   (HOLD_TICKS),
      .OFS_BITS     (OFS_BITS),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n),
      .sw         (sw),
      .done       (done),
      .count_in   (count_in),
      .go         (go),
      .start      (start),
      .n_disp     (n_disp),
      .count_disp (count_disp),
      .busy       (busy),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Reference timing: free-running tick and the 2-flop delayed key levels.
   logic [TICK_BITS-1:0] pre_m;
   logic [3:0]           key_s1;
   logic [3:0]           key_s2;
   int                   ticks_inc = 0;
   int                   ticks_inc_only = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_m  <= '0;
         key_s1 <= 4'hF;
         key_s2 <= 4'hF;
      end else begin
         pre_m  <= pre_m + 1'b1;
         key_s1 <= key_n;
         key_s2 <= key_s1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && pre_m == '0) begin
         if (!key_s2[KEY_INC]) ticks_inc++;
         if (!key_s2[KEY_INC] && key_s2[KEY_CLR]) ticks_inc_only++;
      end
   end

   // Scoreboards: expected go cycles, and expected start/n_disp after each stimulus.
   int go_q[$];
   logic go_last = 1'b0;

   typedef struct {
      string       tag;
      logic [31:0] exp_start;
      logic [11:0] exp_n;
   } exp_t;
   exp_t exp_q[$];

   always @(negedge clk) begin
      if (go) begin
         checkOutput("go_expected", 32'(go_q.size() > 0), 1);
         if (go_q.size() > 0) checkOutput("go_latency", cyc, go_q.pop_front());
         checkOutput("go_single", 32'(go_last), 0);
      end
      go_last = go;
   end

   task automatic expectStart(input string tag, input int s, input int n);
      exp_t e;
      e.tag = tag;
      e.exp_start = 32'(s);
      e.exp_n = 12'(n);
      exp_q.push_back(e);
   endtask

   task automatic drainCheck();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput({e.tag, "_start"}, start, e.exp_start);
         checkOutput({e.tag, "_ndisp"}, 32'(n_disp), 32'(e.exp_n));
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input int low_cycles, input int settle, input bit expect_go);
      @(negedge clk);
      if (expect_go) go_q.push_back(cyc + 3);
      key_n = key_n & ~mask;
      repeat (low_cycles) @(negedge clk);
      key_n = key_n | mask;
      repeat (settle) @(negedge clk);
   endtask

   task automatic waitIdle(input string tag, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] bench did not finish");
   end

   int base_m = 0;
   int ofs_m = 0;
   int steps;

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst_go", 32'(go), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_start", start, 0);
      checkOutput("rst_count_disp", 32'(count_disp), 0);
      checkOutput("rst_timeout", 32'(timeout), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Launch from IDLE; run stays busy while done is low.
      sw = 10'd27;
      base_m = 27;
      applyStimulus(4'b1000, 20, 2, 1);
      checkOutput("launch1_busy", 32'(busy), 1);
      sw = 10'd500;
      count_in = 16'h1234;
      repeat (2) @(negedge clk);
      expectStart("launch1_wait", base_m, base_m);
      drainCheck();
      checkOutput("count_hold_idle", 32'(count_disp), 0);
      done = 1'b1;
      waitIdle("browse1_reached", 20);
      repeat (2) @(negedge clk);
      expectStart("browse1", ofs_m, base_m + ofs_m);
      drainCheck();
      checkOutput("count_browse", 32'(count_disp), 32'h1234);

      // Relaunch with stale done high; only the second rising level ends the wait.
      sw = 10'd100;
      base_m = 100;
      applyStimulus(4'b1000, 4, 2, 1);
      count_in = 16'h5555;
      repeat (5) @(negedge clk);
      checkOutput("stale_done_busy", 32'(busy), 1);
      checkOutput("count_hold_wait", 32'(count_disp), 32'h1234);
      done = 1'b0;
      applyStimulus(4'b1000, 3, 6, 0);
      checkOutput("wait_high_busy", 32'(busy), 1);
      expectStart("wait_high", base_m, base_m);
      drainCheck();
      done = 1'b1;
      waitIdle("browse2_reached", 20);

      // Single taps: decrement wraps below zero, increment wraps back.
      applyStimulus(4'b0010, 3, 8, 0);
      ofs_m = 255;
      expectStart("tap_dec", ofs_m, base_m + ofs_m);
      drainCheck();
      applyStimulus(4'b0001, 3, 8, 0);
      ofs_m = 0;
      expectStart("tap_inc", ofs_m, base_m + ofs_m);
      drainCheck();

      // Long hold: one press step, then one step per tick after HOLD_TICKS ticks.
      @(negedge clk);
      ticks_inc = 0;
      applyStimulus(4'b0001, 200, 8, 0);
      steps = 1 + ((ticks_inc > HOLD_TICKS) ? ticks_inc - HOLD_TICKS : 0);
      ofs_m = (ofs_m + steps) % 256;
      expectStart("hold_inc", ofs_m, base_m + ofs_m);
      drainCheck();

      // Inc+dec+clear together: clear wins; then inc wins over dec.
      @(negedge clk);
      key_n = 4'b1000;
      repeat (100) @(negedge clk);
      expectStart("all_clear", 0, base_m);
      drainCheck();
      ticks_inc_only = 0;
      key_n[KEY_CLR] = 1'b1;
      repeat (64) @(negedge clk);
      key_n = 4'hF;
      repeat (8) @(negedge clk);
      ofs_m = ticks_inc_only % 256;
      expectStart("inc_priority", ofs_m, base_m + ofs_m);
      drainCheck();

      // Clear works mid-run; increments outside BROWSE are ignored.
      sw = 10'd300;
      base_m = 300;
      applyStimulus(4'b1000, 3, 4, 1);
      applyStimulus(4'b0100, 5, 4, 0);
      applyStimulus(4'b0001, 3, 4, 0);
      done = 1'b0;
      repeat (3) @(negedge clk);
      done = 1'b1;
      waitIdle("browse3_reached", 20);
      ofs_m = 0;
      expectStart("clear_in_wait", ofs_m, base_m);
      drainCheck();

      // Reset mid-run returns to IDLE with cleared registers.
      sw = 10'd55;
      applyStimulus(4'b1000, 3, 8, 1);
      checkOutput("midrun_busy", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrun_rst_busy", 32'(busy), 0);
      checkOutput("midrun_rst_start", start, 0);
      checkOutput("midrun_rst_ndisp", 32'(n_disp), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

`ifdef RANGE_CTRL_TIMEOUT_EN
      done = 1'b0;
      sw = 10'd9;
      applyStimulus(4'b1000, 3, 37, 1);
      checkOutput("wd_not_early", 32'(busy), 1);
      checkOutput("wd_flag_early", 32'(timeout), 0);
      waitIdle("wd_expire_idle", 60);
      checkOutput("wd_timeout_set", 32'(timeout), 1);
      checkOutput("wd_idle_start", start, 9);
      applyStimulus(4'b1000, 3, 4, 1);
      checkOutput("wd_timeout_clear", 32'(timeout), 0);
      checkOutput("wd_relaunch_busy", 32'(busy), 1);
`else
      done = 1'b0;
      sw = 10'd9;
      applyStimulus(4'b1000, 3, 80, 1);
      checkOutput("no_wd_busy", 32'(busy), 1);
      checkOutput("no_wd_timeout", 32'(timeout), 0);
`endif

      repeat (4) @(negedge clk);
      checkOutput("go_all_seen", go_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
